// File: rtl/deca_qsys_led_pio_pkg.sv
// Shared definitions for the DECA LED/GPO output PIO: register map and field widths.
package deca_qsys_led_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_BLINK  = 3'd1;
    localparam logic [2:0] ADDR_HALF   = 3'd2;
    localparam logic [2:0] ADDR_PLEN   = 3'd3;
    localparam logic [2:0] ADDR_PSTART = 3'd4;
    localparam logic [2:0] ADDR_OUTSET = 3'd5;
    localparam logic [2:0] ADDR_OUTCLR = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam int HALF_W = 16;
    localparam int PLEN_W = 16;

    // A programmed half-period of 0 is treated as 1 tick.
    function automatic logic [HALF_W-1:0] half_eff(input logic [HALF_W-1:0] h);
        return (h == '0) ? HALF_W'(1) : h;
    endfunction

endpackage

// File: rtl/deca_qsys_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO (no wait states, 1-cycle read latency).
interface deca_qsys_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input readdata);
    modport slave  (input address, input chipselect, input write_n, input writedata,
                    output readdata);
endinterface

// File: rtl/deca_qsys_led_tick.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks, shared by DECA peripherals.
module deca_qsys_led_tick #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pcnt;

    // Count 0..PRESCALE-1 and wrap; never restarted by anything but reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pcnt <= '0;
        else if (pcnt == LAST)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    assign tick = (pcnt == LAST);
endmodule

// File: rtl/deca_qsys_led_pio.sv
// LED/GPO output PIO: static data with set/clear aliases, per-bit blink and pulse stretcher.
module deca_qsys_led_pio
    import deca_qsys_led_pio_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    deca_qsys_led_pio_if.slave   bus,
    output logic [WIDTH-1:0]     out_port
);
    logic              tick;
    logic              wr;
    logic              half_wr;
    logic              pstart_wr;
    logic              expire;
    logic [WIDTH-1:0]  wr_mask;
    logic [WIDTH-1:0]  data_r;
    logic [WIDTH-1:0]  blink_r;
    logic [HALF_W-1:0] half_r;
    logic [PLEN_W-1:0] plen_r;
    logic [HALF_W-1:0] hcnt;
    logic [HALF_W-1:0] half_last;
    logic              phase;
    logic [WIDTH-1:0]  pulse_active;
    logic [PLEN_W-1:0] pcount;
    logic [WIDTH-1:0]  out_nxt;
    logic [WIDTH-1:0]  out_p1;
    logic [31:0]       rd_mux;
    logic [31:0]       rd_p1;
    logic              unused_wdata;

    deca_qsys_led_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wr           = bus.chipselect & ~bus.write_n;
    assign wr_mask      = bus.writedata[WIDTH-1:0];
    assign half_wr      = wr && (bus.address == ADDR_HALF);
    assign pstart_wr    = wr && (bus.address == ADDR_PSTART) && (plen_r != '0);
    assign half_last    = half_eff(half_r) - HALF_W'(1);
    assign expire       = tick && (|pulse_active) && (pcount == PLEN_W'(1));
    assign unused_wdata = ^bus.writedata[31:16];

    // Register file writes, including the DATA set/clear aliases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r  <= '0;
            blink_r <= '0;
            half_r  <= '0;
            plen_r  <= '0;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:   data_r  <= wr_mask;
                ADDR_BLINK:  blink_r <= wr_mask;
                ADDR_HALF:   half_r  <= bus.writedata[HALF_W-1:0];
                ADDR_PLEN:   plen_r  <= bus.writedata[PLEN_W-1:0];
                ADDR_OUTSET: data_r  <= data_r | wr_mask;
                ADDR_OUTCLR: data_r  <= data_r & ~wr_mask;
                default:     ;
            endcase
        end
    end

    // Blink phase: toggles every max(HALF,1) ticks; a HALF write restarts the count only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt  <= '0;
            phase <= 1'b0;
        end else if (half_wr) begin
            hcnt <= '0;
        end else if (tick) begin
            if (hcnt == half_last) begin
                hcnt  <= '0;
                phase <= ~phase;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Pulse stretcher: a start retriggers all active bits; a start on the expiry tick wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_active <= '0;
            pcount       <= '0;
        end else if (pstart_wr) begin
            pulse_active <= expire ? wr_mask : (pulse_active | wr_mask);
            pcount       <= plen_r;
        end else if (tick && (|pulse_active)) begin
            if (pcount == PLEN_W'(1)) begin
                pulse_active <= '0;
                pcount       <= '0;
            end else begin
                pcount <= pcount - 1'b1;
            end
        end
    end

    // Blinking bits pass DATA only while phase is high; pulses force the bit on.
    always_comb begin
        out_nxt = pulse_active | (data_r & (~blink_r | {WIDTH{phase}}));
    end

    // Read mux; unused upper bits stay zero.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:   rd_mux[WIDTH-1:0]  = data_r;
            ADDR_BLINK:  rd_mux[WIDTH-1:0]  = blink_r;
            ADDR_HALF:   rd_mux[HALF_W-1:0] = half_r;
            ADDR_PLEN:   rd_mux[PLEN_W-1:0] = plen_r;
            ADDR_PSTART: rd_mux[WIDTH-1:0]  = pulse_active;
            ADDR_STATUS: rd_mux[WIDTH-1:0]  = out_p1;
            default:     rd_mux = '0;
        endcase
    end

    // Registered pins and read data, both cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_p1 <= '0;
            rd_p1  <= '0;
        end else begin
            out_p1 <= out_nxt;
            rd_p1  <= rd_mux;
        end
    end

    assign out_port     = out_p1;
    assign bus.readdata = rd_p1;
endmodule

// File: tb/tb_deca_qsys_led_pio.sv
// Directed bench for deca_qsys_led_pio with WIDTH=8, PRESCALE=4.
module tb_deca_qsys_led_pio;
    localparam int WIDTH    = 8;
    localparam int PRESCALE = 4;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;
    int               cyc   = 0;
    int               total = 0;
    int               bad   = 0;

    deca_qsys_led_pio_if bus ();

    deca_qsys_led_pio #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to line writes up with prescaler ticks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    // Measures intervals between steady-state toggles of out_port[0].
    task automatic measure_toggle(output int i1, output int i2, output int others);
        int   t[4];
        int   n;
        logic prev;
        t = '{default: 0};
        n = 0;
        others = 0;
        prev = out_port[0];
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (out_port[WIDTH-1:1] != '0) others++;
            if (out_port[0] !== prev) begin
                if (n < 4) t[n] = cyc;
                n++;
                prev = out_port[0];
            end
        end
        i1 = (n >= 3) ? t[2] - t[1] : 0;
        i2 = (n >= 4) ? t[3] - t[2] : 0;
    endtask

    initial begin
        logic [31:0] rd;
        int i1, i2, oth, width, seen, tph, fall, cnt40;

        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_rd", bus.readdata, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write: visible two clocks after the write edge.
        wr_reg(3'd0, 32'hA5);
        chk("data_lag", 32'(out_port), 32'h0);
        @(negedge clk);
        chk("data_out", 32'(out_port), 32'hA5);
        rd_reg(3'd0, rd);
        chk("data_rd", rd, 32'h0000_00A5);

        // Set/clear aliases.
        wr_reg(3'd0, 32'h0F);
        wr_reg(3'd5, 32'hF0);
        wr_reg(3'd6, 32'h03);
        rd_reg(3'd0, rd);
        chk("setclr_data", rd, 32'hFC);
        rd_reg(3'd7, rd);
        chk("setclr_status", rd, 32'hFC);
        rd_reg(3'd5, rd);
        chk("outset_rd0", rd, 32'h0);

        // Blink with HALF=2 then HALF=0.
        wr_reg(3'd0, 32'h01);
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd2, 32'h2);
        measure_toggle(i1, i2, oth);
        chk("blink8_a", 32'(i1), 32'd8);
        chk("blink8_b", 32'(i2), 32'd8);
        chk("blink_others", 32'(oth), 32'd0);
        wr_reg(3'd2, 32'h0);
        measure_toggle(i1, i2, oth);
        chk("blink4_a", 32'(i1), 32'd4);
        chk("blink4_b", 32'(i2), 32'd4);

        // Pulse with PLEN=3.
        wr_reg(3'd1, 32'h0);
        wr_reg(3'd0, 32'h0);
        wr_reg(3'd3, 32'd3);
        repeat (2) @(negedge clk);
        chk("pre_pulse", 32'(out_port), 32'h0);
        wr_reg(3'd4, 32'h80);
        width = 0;
        seen  = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_port[7]) begin
                if (width == 0) chk("pstart_active", bus.readdata, 32'h80);
                width++;
            end
            if (out_port[6:0] != '0) seen++;
        end
        chk("pulse_width_ok", 32'((width >= 9) && (width <= 12)), 32'd1);
        chk("pulse_others", 32'(seen), 32'd0);
        rd_reg(3'd4, rd);
        chk("pstart_idle", rd, 32'h0);

        // Find the prescaler phase from a one-tick pulse.
        wr_reg(3'd3, 32'd1);
        wr_reg(3'd4, 32'h80);
        seen = 0;
        fall = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (out_port[7]) seen = 1;
            else if (seen == 1 && fall < 0) fall = cyc;
        end
        chk("plen1_fall_seen", 32'(fall >= 0), 32'd1);
        tph = (fall - 1) % PRESCALE;

        // Collision: new start lands exactly on the expiry tick of the running pulse.
        wr_reg(3'd3, 32'd3);
        for (int k = 0; k < 8; k++) begin
            if ((cyc + 2) % PRESCALE == tph) break;
            @(negedge clk);
        end
        wr_reg(3'd4, 32'h80);
        repeat (10) @(negedge clk);
        wr_reg(3'd4, 32'h40);
        chk("coll_before", 32'(out_port), 32'h80);
        @(negedge clk);
        chk("coll_after", 32'(out_port), 32'h40);
        cnt40 = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_port == 8'h40) cnt40++;
        end
        chk("coll_width", 32'(cnt40), 32'd12);

        // PSTART with PLEN=0 does nothing.
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd4, 32'h01);
        repeat (8) @(negedge clk);
        chk("plen0_out", 32'(out_port), 32'h0);
        rd_reg(3'd4, rd);
        chk("plen0_active", rd, 32'h0);

        // Asynchronous reset during blink plus an active pulse.
        wr_reg(3'd3, 32'd5);
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd1, 32'h0F);
        wr_reg(3'd2, 32'd1);
        wr_reg(3'd4, 32'h80);
        bus.address = 3'd0;
        repeat (3) @(negedge clk);
        chk("pre_rst_out", 32'(out_port[7:4]), 32'hF);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_out", 32'(out_port), 32'h0);
        chk("async_rd", bus.readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd_reg(3'd2, rd);
        chk("post_half", rd, 32'h0);
        wr_reg(3'd2, 32'hFFFF);
        rd_reg(3'd0, rd);
        chk("post_data", rd, 32'h0);
        rd_reg(3'd1, rd);
        chk("post_blink", rd, 32'h0);
        rd_reg(3'd3, rd);
        chk("post_plen", rd, 32'h0);
        rd_reg(3'd4, rd);
        chk("post_pstart", rd, 32'h0);
        rd_reg(3'd7, rd);
        chk("post_status", rd, 32'h0);
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd0, 32'h01);
        repeat (2) @(negedge clk);
        chk("post_phase0", 32'(out_port), 32'h0);
        wr_reg(3'd1, 32'h00);
        repeat (2) @(negedge clk);
        chk("post_data_out", 32'(out_port), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
